// File: rtl/wb_unit.sv
// Write-back stage feeding the register file write port: merges load returns and ALU results.
// Optional load timeout enabled by defining WB_LOAD_TIMEOUT_EN.
module wb_unit #(
  parameter int unsigned PW  = 3,
  parameter int unsigned TMO = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [PW:0]   alu_dest,
  input  logic [7:0]    alu_result,
  input  logic          ld_req,
  input  logic [PW:0]   ld_dest,
  input  logic          mem_rvalid,
  input  logic [7:0]    mem_rdata,
  output logic          stall,
  output logic          busy,
  output logic          wr_en,
  output logic [PW:0]   wr_addr,
  output logic [7:0]    dat_in,
  output logic          fwd_valid,
  output logic [PW:0]   fwd_addr,
  output logic [7:0]    fwd_data,
  output logic          err
);

  // The timeout counter is 8 bits wide, so the abort point must fit in it.
  if (TMO < 2 || TMO > 256) begin : g_bad_tmo
    $error("wb_unit: TMO must be in 2..256");
  end

  typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

  state_e      state_q, state_d;
  logic [PW:0] pend_q, pend_d;
  logic        hold_valid_q, hold_valid_d;
  logic [PW:0] hold_addr_q, hold_addr_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        wr_en_q, wr_en_d;
  logic [PW:0] wr_addr_q, wr_addr_d;
  logic [7:0]  dat_q, dat_d;
  logic        err_q, err_d;
`ifdef WB_LOAD_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic in_wait, ld_ret, alu_acc, ld_acc;

  assign in_wait = (state_q == StLoadWait);
  assign ld_ret  = in_wait & mem_rvalid;

  // Last term: an ALU write to the pending load's register must not be overtaken by the load.
  assign stall = hold_valid_q
               | (in_wait & ld_req & ~mem_rvalid)
               | (in_wait & alu_valid & (alu_dest == pend_q) & ~mem_rvalid);

  assign alu_acc = alu_valid & ~stall;
  assign ld_acc  = ld_req & ~stall;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    dat_d        = dat_q;
    err_d        = err_q;
`ifdef WB_LOAD_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    // Write selection: load return, then hold buffer, then ALU.
    if (ld_ret) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pend_q;
      dat_d     = mem_rdata;
      if (alu_acc) begin
        hold_valid_d = 1'b1;
        hold_addr_d  = alu_dest;
        hold_data_d  = alu_result;
      end
    end else if (hold_valid_q) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = hold_addr_q;
      dat_d        = hold_data_q;
      hold_valid_d = 1'b0;
    end else if (alu_acc) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_dest;
      dat_d     = alu_result;
    end

    case (state_q)
      StIdle: begin
        if (mem_rvalid) err_d = 1'b1;
        if (ld_acc) begin
          state_d = StLoadWait;
          pend_d  = ld_dest;
`ifdef WB_LOAD_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      StLoadWait: begin
        if (mem_rvalid) begin
          if (ld_acc) begin
            pend_d = ld_dest;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_d  = 8'd0;
`endif
          end else begin
            state_d = StIdle;
          end
        end
`ifdef WB_LOAD_TIMEOUT_EN
        else if (cnt_q == 8'(TMO - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      dat_q        <= '0;
      err_q        <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      dat_q        <= dat_d;
      err_q        <= err_d;
`ifdef WB_LOAD_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign busy      = in_wait;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign dat_in    = dat_q;
  assign fwd_valid = wr_en_q;
  assign fwd_addr  = wr_addr_q;
  assign fwd_data  = dat_q;
  assign err       = err_q;

endmodule
